// File: rtl/x_counter_ctrl_pkg.sv
// Shared types for the x_counter_ctrl interval timer: controller states and command codes.
package x_counter_ctrl_pkg;

   localparam int CMD_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [CMD_W-1:0] {
      CMD_START = 2'd0,
      CMD_STOP  = 2'd1,
      CMD_CLEAR = 2'd2,
      CMD_LOAD  = 2'd3
   } cmd_e;

endpackage

// File: rtl/x_counter_ctrl_shift.sv
// Serial compare loader: captures one bit per enabled cycle, LSB first, and flags the last bit.
module x_counter_ctrl_shift
   import x_counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             sdata,
   output logic [WIDTH-1:0] compare,
   output logic             done
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [IDX_W-1:0] idx_r;
   logic [WIDTH-1:0] compare_r;

   // Bit index and compare register; compare powers up all-ones so an unloaded timer never matches early.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_r     <= '0;
         compare_r <= '1;
      end else if (clear) begin
         idx_r     <= '0;
         compare_r <= '0;
      end else if (shift_en) begin
         compare_r[idx_r] <= sdata;
         idx_r            <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_ONE;
      end else begin
         idx_r     <= idx_r;
         compare_r <= compare_r;
      end
   end

   assign compare = compare_r;
   assign done    = shift_en && (idx_r == LAST_IDX);

endmodule

// File: rtl/x_counter_ctrl.sv
// Command-driven interval timer controller with serial compare loading.
// Build option: define X_COUNTER_CTRL_AUTO_RELOAD_EN for periodic (auto-reload) operation.
module x_counter_ctrl
   import x_counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   input  logic [CMD_W-1:0] i_cmd,
   output logic             o_cmd_ready,
   input  logic             i_sdata,
   output logic             o_busy,
   output logic             o_expired,
   output logic             o_wrap,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_e           state_r, state_next_s;
   logic [WIDTH-1:0] count_r, count_next_s;
   logic             cmd_ready_r, busy_r, expired_r, wrap_r;
   logic             expired_next_s, wrap_next_s, load_clear_s;
   logic             cmd_acc_s, load_done_s;
   logic [WIDTH-1:0] compare_s;
   cmd_e             cmd_s;

   assign cmd_s     = cmd_e'(i_cmd);
   assign cmd_acc_s = i_cmd_valid && cmd_ready_r;

   x_counter_ctrl_shift #(.WIDTH(WIDTH)) u_shift (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .clear    (load_clear_s),
      .shift_en (state_r == ST_LOAD),
      .sdata    (i_sdata),
      .compare  (compare_s),
      .done     (load_done_s)
   );

   // Next-state, next-count and pulse decode; STOP/CLEAR in RUN take precedence over the count step.
   always_comb begin
      state_next_s   = state_r;
      count_next_s   = count_r;
      expired_next_s = 1'b0;
      wrap_next_s    = 1'b0;
      load_clear_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (cmd_acc_s) begin
               case (cmd_s)
                  CMD_START: begin
                     state_next_s = ST_RUN;
                     count_next_s = (state_r == ST_DONE) ? '0 : count_r;
                  end
                  CMD_CLEAR: begin
                     state_next_s = ST_IDLE;
                     count_next_s = '0;
                  end
                  CMD_LOAD: begin
                     state_next_s = ST_LOAD;
                     load_clear_s = 1'b1;
                  end
                  default: state_next_s = state_r;
               endcase
            end else begin
               state_next_s = state_r;
            end
         end
         ST_LOAD: begin
            if (load_done_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (cmd_acc_s && (cmd_s == CMD_STOP)) begin
               state_next_s = ST_IDLE;
            end else if (cmd_acc_s && (cmd_s == CMD_CLEAR)) begin
               state_next_s = ST_IDLE;
               count_next_s = '0;
            end else if (count_r == compare_s) begin
               expired_next_s = 1'b1;
`ifdef X_COUNTER_CTRL_AUTO_RELOAD_EN
               count_next_s   = '0;
`else
               state_next_s   = ST_DONE;
`endif
            end else if (count_r == '1) begin
               count_next_s = '0;
               wrap_next_s  = 1'b1;
            end else begin
               count_next_s = count_r + CNT_ONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            count_next_s = '0;
         end
      endcase
   end

   // State, count and registered status/pulse outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= ST_IDLE;
         count_r     <= '0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         expired_r   <= 1'b0;
         wrap_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         count_r     <= count_next_s;
         cmd_ready_r <= (state_next_s != ST_LOAD);
         busy_r      <= (state_next_s == ST_LOAD) || (state_next_s == ST_RUN);
         expired_r   <= expired_next_s;
         wrap_r      <= wrap_next_s;
      end
   end

   assign o_cmd_ready = cmd_ready_r;
   assign o_busy      = busy_r;
   assign o_expired   = expired_r;
   assign o_wrap      = wrap_r;
   assign o_count     = count_r;

endmodule
